// File: rtl/acc_cpu_if.sv
// -----------------------------------------------------------------------------
// acc_cpu_if -- bus bundle between acc_cpu and its memory / port environment.
//
// Parameters
//   DW : data / instruction width
//   AW : address width of each memory (program counter width)
//
// Signals
//   ar      [AW:0]  address; ar[AW]=1 selects program EPROM, 0 selects data SRAM
//   rd              memory read strobe
//   wr              memory write strobe (never together with rd)
//   buf_in  [DW-1:0] input port, read by IN
//   buf_out [DW-1:0] registered output port, written by OUT
//   carry           carry flag of the last ADD
//   halt            high while the CPU sits in its halted state
//
// Modports
//   master : the CPU side (drives address/strobes/ports, reads buf_in)
//   slave  : the environment side (memories, input port driver)
//
// The shared data bus dr is a resolved tri-state net, so it is not part of
// this bundle; it is a plain inout port of acc_cpu.
// -----------------------------------------------------------------------------
interface acc_cpu_if #(
  parameter int DW = 8,
  parameter int AW = 4
) ();
  logic [AW:0]   ar;
  logic          rd;
  logic          wr;
  logic [DW-1:0] buf_in;
  logic [DW-1:0] buf_out;
  logic          carry;
  logic          halt;

  modport master (
    output ar, rd, wr, buf_out, carry, halt,
    input  buf_in
  );

  modport slave (
    input  ar, rd, wr, buf_out, carry, halt,
    output buf_in
  );
endinterface

// File: rtl/acc_cpu.sv
// -----------------------------------------------------------------------------
// acc_cpu -- minimal accumulator CPU with a 4-clock instruction cycle.
//
// Every instruction walks IF1 -> IF2 -> ID -> EX, one clock each. The word
// fetched from the program EPROM holds a 3-bit opcode in its top bits and an
// AW-bit operand address in its low bits:
//   000 IN    acc <= buf_in          100 ADD  {carry,acc} <= acc + sram[a]
//   001 OUT   buf_out <= acc         101 JMP  pc <= a
//   010 STORE sram[a] <= acc         110 JZ   pc <= a when acc == 0
//   011 LOAD  acc <= sram[a]         111 HLT  stop until reset
//
// Ports
//   clk  : system clock, all state changes on its rising edge
//   rst  : synchronous active-high reset; also forces rd/wr low and releases
//          dr combinationally while high
//   dr   : shared memory data bus (inout, driven only during a STORE write)
//   bus  : acc_cpu_if master modport (ar, rd, wr, buf_in, buf_out, carry, halt)
//
// Build option
//   ACC_CPU_ADD_EN : when defined, opcode 100 is ADD. When undefined, opcode
//                    100 is a plain 4-clock NOP, carry is tied low and no
//                    adder exists.
//
// Bus outputs (ar/rd/wr and the dr drive enable) are registered: each cycle
// the next values are computed for the state being entered, so the strobes
// are glitch-free during a state.
// -----------------------------------------------------------------------------
module acc_cpu #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [DW-1:0] dr,
  acc_cpu_if.master     bus
);

  typedef enum logic [2:0] {
    S_IF1    = 3'd0,
    S_IF2    = 3'd1,
    S_ID     = 3'd2,
    S_EX     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] OP_IN    = 3'b000;
  localparam logic [2:0] OP_OUT   = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_HLT   = 3'b111;

  // Architectural and control state
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] buf_out_q, buf_out_d;
  logic          halt_q, halt_d;

  // Registered bus outputs for the current state
  logic [AW:0]   ar_q, ar_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;

  // Decoded fields of the current instruction and of the one held next cycle
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] a_q;
  logic          op_reads_d;

`ifdef ACC_CPU_ADD_EN
  logic          carry_q, carry_d;
  logic [DW:0]   sum;

  // During EX of ADD the memory is driving dr with sram[a].
  assign sum = {1'b0, acc_q} + {1'b0, dr};
`endif

  assign op_q = ir_q[DW-1:DW-3];
  assign a_q  = ir_q[AW-1:0];
  assign op_d = ir_d[DW-1:DW-3];

  // Only the opcode and the address field are architecturally meaningful;
  // any bits in between are ignored.
  logic unused_ir;
  assign unused_ir = ^ir_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    buf_out_d = buf_out_q;
    halt_d    = halt_q;
`ifdef ACC_CPU_ADD_EN
    carry_d   = carry_q;
`endif

    case (state_q)
      S_IF1: begin
        state_d = S_IF2;
      end

      S_IF2: begin
        // The EPROM word is on dr for the whole IF2 cycle.
        ir_d    = dr;
        pc_d    = pc_q + 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        state_d = S_EX;
        case (op_q)
          OP_IN:   acc_d     = bus.buf_in;
          OP_OUT:  buf_out_d = acc_q;
          OP_JMP:  pc_d      = a_q;
          OP_JZ:   if (acc_q == '0) pc_d = a_q;
          OP_HLT: begin
            state_d = S_HALTED;
            halt_d  = 1'b1;
          end
          default: ;
        endcase
      end

      S_EX: begin
        state_d = S_IF1;
        case (op_q)
          OP_LOAD: acc_d = dr;
`ifdef ACC_CPU_ADD_EN
          OP_ADD:  {carry_d, acc_d} = sum;
`endif
          default: ;
        endcase
      end

      S_HALTED: begin
        // Frozen; only reset leaves this state.
        state_d = S_HALTED;
      end

      default: state_d = S_IF1;
    endcase
  end

  // Next-state bus outputs, derived from the state being entered and the
  // instruction that will be held in it.
  always_comb begin
`ifdef ACC_CPU_ADD_EN
    op_reads_d = (op_d == OP_LOAD) || (op_d == OP_ADD);
`else
    op_reads_d = (op_d == OP_LOAD);
`endif
    ar_d = '0;
    rd_d = 1'b0;
    wr_d = 1'b0;
    case (state_d)
      S_IF1, S_IF2: begin
        ar_d = {1'b1, pc_d};
        rd_d = 1'b1;
      end
      S_ID: begin
        ar_d = {1'b0, ir_d[AW-1:0]};
        rd_d = op_reads_d;
      end
      S_EX: begin
        ar_d = {1'b0, ir_d[AW-1:0]};
        rd_d = op_reads_d;
        wr_d = (op_d == OP_STORE);
      end
      default: begin
        ar_d = '0;
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IF1;
      pc_q      <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      buf_out_q <= '0;
      halt_q    <= 1'b0;
      // Outputs for the IF1 that follows reset release.
      ar_q      <= {1'b1, {AW{1'b0}}};
      rd_q      <= 1'b1;
      wr_q      <= 1'b0;
`ifdef ACC_CPU_ADD_EN
      carry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      buf_out_q <= buf_out_d;
      halt_q    <= halt_d;
      ar_q      <= ar_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
`ifdef ACC_CPU_ADD_EN
      carry_q   <= carry_d;
`endif
    end
  end

  // Strobes and the bus driver are masked by rst without waiting for a clock,
  // so a reset that lands on a STORE EX never lets the write through.
  assign bus.ar      = ar_q;
  assign bus.rd      = rd_q & ~rst;
  assign bus.wr      = wr_q & ~rst;
  assign bus.buf_out = buf_out_q;
  assign bus.halt    = halt_q;
`ifdef ACC_CPU_ADD_EN
  assign bus.carry   = carry_q;
`else
  assign bus.carry   = 1'b0;
`endif

  assign dr = (wr_q && !rst) ? acc_q : {DW{1'bz}};

endmodule

// File: tb/tb_acc_cpu.sv
`timescale 1ns/1ps
module tb_acc_cpu;
  localparam int DW = 8;
  localparam int AW = 4;

`ifdef ACC_CPU_ADD_EN
  localparam bit ADD_EN = 1'b1;
`else
  localparam bit ADD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire [DW-1:0] dr;
  acc_cpu_if #(.DW(DW), .AW(AW)) bus ();
  acc_cpu #(.DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .dr  (dr),
    .bus (bus)
  );

  // Environment: 16-word program EPROM and 16-word data SRAM
  logic [7:0] eprom [16];
  logic [7:0] sram  [16];
  logic       poke_en   = 1'b0;
  logic [3:0] poke_addr = 4'd0;
  logic [7:0] poke_data = 8'd0;
  logic [7:0] mem_rd;

  assign mem_rd = bus.ar[4] ? eprom[bus.ar[3:0]] : sram[bus.ar[3:0]];
  assign dr     = (bus.rd && !bus.wr) ? mem_rd : 8'hzz;

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 8'h00;
    forever begin
      @(posedge clk);
      if (poke_en) sram[poke_addr] = poke_data;
      else if (bus.wr) sram[bus.ar[3:0]] = dr;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: architectural state plus the four-phase bus
  // schedule every instruction follows; checked on every falling edge.
  initial begin : model_cmp
    logic [3:0] m_pc;
    logic [7:0] m_ir, m_acc, m_out;
    logic       m_c, m_halt;
    logic [7:0] m_sram [16];
    logic [2:0] op;
    logic [3:0] a;
    logic [4:0] e_ar;
    logic       e_rd, e_wr;
    int         phase;
    bit         rst_prev;
    m_pc = 0; m_ir = 0; m_acc = 0; m_out = 0; m_c = 0; m_halt = 0;
    phase = 0; rst_prev = 0;
    for (int i = 0; i < 16; i++) m_sram[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_rd", {31'd0, bus.rd}, 32'd0);
        check("rst_wr", {31'd0, bus.wr}, 32'd0);
        if (rst_prev) begin
          check("rst_buf_out", {24'd0, bus.buf_out}, 32'd0);
          check("rst_carry", {31'd0, bus.carry}, 32'd0);
          check("rst_halt", {31'd0, bus.halt}, 32'd0);
        end
        m_pc = 0; m_ir = 0; m_acc = 0; m_out = 0; m_c = 0; m_halt = 0; phase = 0;
      end else begin
        if (phase == 0 && !m_halt) m_ir = eprom[m_pc];
        op = m_ir[7:5];
        a  = m_ir[3:0];
        if (m_halt) begin
          e_ar = 5'd0; e_rd = 1'b0; e_wr = 1'b0;
        end else if (phase < 2) begin
          e_ar = {1'b1, m_pc}; e_rd = 1'b1; e_wr = 1'b0;
        end else begin
          e_ar = {1'b0, a};
          e_rd = (op == 3'b011) || (ADD_EN && op == 3'b100);
          e_wr = (phase == 3) && (op == 3'b010);
        end
        check("m_ar", {27'd0, bus.ar}, {27'd0, e_ar});
        check("m_rd", {31'd0, bus.rd}, {31'd0, e_rd});
        check("m_wr", {31'd0, bus.wr}, {31'd0, e_wr});
        check("m_buf_out", {24'd0, bus.buf_out}, {24'd0, m_out});
        check("m_carry", {31'd0, bus.carry}, {31'd0, m_c});
        check("m_halt", {31'd0, bus.halt}, {31'd0, m_halt});
        if (e_wr) check("m_store_data", {24'd0, dr}, {24'd0, m_acc});
        if (!m_halt) begin
          if (phase == 1) m_pc = m_pc + 4'd1;
          else if (phase == 2) begin
            case (op)
              3'b000: m_acc = bus.buf_in;
              3'b001: m_out = m_acc;
              3'b101: m_pc = a;
              3'b110: if (m_acc == 8'd0) m_pc = a;
              3'b111: m_halt = 1'b1;
              default: ;
            endcase
          end else if (phase == 3) begin
            case (op)
              3'b010: m_sram[a] = m_acc;
              3'b011: m_acc = m_sram[a];
              3'b100: if (ADD_EN) {m_c, m_acc} = {1'b0, m_acc} + {1'b0, m_sram[a]};
              default: ;
            endcase
          end
          phase = (phase + 1) % 4;
        end
      end
      if (poke_en) m_sram[poke_addr] = poke_data;
      rst_prev = rst;
    end
  end

  // Stimulus helpers. cur = index of the current cycle since reset release.
  int cur = 0;

  task automatic to_neg(input int k);
    while (cur < k) begin
      @(posedge clk);
      cur++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic begin_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) eprom[i] = 8'hE0;
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(posedge clk);
    #2;
    poke_en   = 1'b0;
  endtask

  task automatic end_reset(input string tag);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_rst_buf_out"}, {24'd0, bus.buf_out}, 32'h00);
    check({tag, "_rst_carry"}, {31'd0, bus.carry}, 32'd0);
    check({tag, "_rst_halt"}, {31'd0, bus.halt}, 32'd0);
    check({tag, "_rst_rd"}, {31'd0, bus.rd}, 32'd0);
    check({tag, "_rst_wr"}, {31'd0, bus.wr}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cur = 0;
  endtask

  initial begin : stim
    bus.buf_in = 8'h00;

    // Program A: IN, STORE 3, IN, LOAD 3, OUT, HLT
    begin_reset();
    eprom[0] = 8'h00; eprom[1] = 8'h43; eprom[2] = 8'h00;
    eprom[3] = 8'h63; eprom[4] = 8'h20; eprom[5] = 8'hE0;
    bus.buf_in = 8'h07;
    end_reset("a");
    to_neg(0);
    check("a_first_ar", {27'd0, bus.ar}, 32'h10);
    check("a_first_rd", {31'd0, bus.rd}, 32'd1);
    to_neg(5);
    bus.buf_in = 8'h09;
    to_neg(22);
    check("a_halt_c22", {31'd0, bus.halt}, 32'd0);
    to_neg(23);
    check("a_halt_c23", {31'd0, bus.halt}, 32'd1);
    check("a_buf_out", {24'd0, bus.buf_out}, 32'h07);
    check("a_sram3", {24'd0, sram[3]}, 32'h07);
    $display("[TB] program A done at cycle %0d", cur);

    // Program B: ADD with overflow, then ADD without carry
    begin_reset();
    eprom[0] = 8'h00; eprom[1] = 8'h82; eprom[2] = 8'h20; eprom[3] = 8'h44;
    eprom[4] = 8'h00; eprom[5] = 8'h42; eprom[6] = 8'h64; eprom[7] = 8'h82;
    eprom[8] = 8'h20; eprom[9] = 8'hE0;
    bus.buf_in = 8'hF0;
    poke(4'd2, 8'h20);
    end_reset("b");
    to_neg(12);
    check("b_mid_buf_out", {24'd0, bus.buf_out}, ADD_EN ? 32'h10 : 32'hF0);
    check("b_mid_carry", {31'd0, bus.carry}, ADD_EN ? 32'd1 : 32'd0);
    bus.buf_in = 8'h01;
    to_neg(40);
    check("b_halt", {31'd0, bus.halt}, 32'd1);
    check("b_buf_out", {24'd0, bus.buf_out}, ADD_EN ? 32'h11 : 32'hF0);
    check("b_carry", {31'd0, bus.carry}, 32'd0);
    $display("[TB] program B done at cycle %0d", cur);

    // Program C: JZ taken, JZ fall-through, JMP to 15, JMP at 15
    begin_reset();
    eprom[0]  = 8'hC9; eprom[9]  = 8'h00; eprom[10] = 8'hC9;
    eprom[11] = 8'hAF; eprom[15] = 8'hA3; eprom[3]  = 8'h20; eprom[4] = 8'hE0;
    bus.buf_in = 8'h05;
    end_reset("c");
    to_neg(4);
    check("c_jz_taken_ar", {27'd0, bus.ar}, 32'h19);
    to_neg(12);
    check("c_jz_fall_ar", {27'd0, bus.ar}, 32'h1B);
    to_neg(16);
    check("c_jmp15_ar", {27'd0, bus.ar}, 32'h1F);
    to_neg(20);
    check("c_jmp_at15_ar", {27'd0, bus.ar}, 32'h13);
    to_neg(27);
    check("c_halt", {31'd0, bus.halt}, 32'd1);
    check("c_buf_out", {24'd0, bus.buf_out}, 32'h05);
    $display("[TB] program C done at cycle %0d", cur);

    // Program D: sequential wrap at 15, reset during STORE EX
    begin_reset();
    eprom[0] = 8'h00; eprom[1] = 8'hAE; eprom[14] = 8'h20; eprom[15] = 8'h45;
    bus.buf_in = 8'h5A;
    poke(4'd5, 8'h00);
    end_reset("d");
    to_neg(16);
    check("d_wrap_ar", {27'd0, bus.ar}, 32'h10);
    check("d_wrap_rd", {31'd0, bus.rd}, 32'd1);
    check("d_sram5_first", {24'd0, sram[5]}, 32'h5A);
    check("d_buf_out", {24'd0, bus.buf_out}, 32'h5A);
    bus.buf_in = 8'hA5;
    to_neg(30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    cur = 31;
    @(negedge clk);
    #1;
    check("d_ex_rst_wr", {31'd0, bus.wr}, 32'd0);
    check("d_ex_rst_rd", {31'd0, bus.rd}, 32'd0);
    end_reset("d2");
    to_neg(0);
    check("d_sram5_kept", {24'd0, sram[5]}, 32'h5A);
    check("d_restart_ar", {27'd0, bus.ar}, 32'h10);
    check("d_restart_rd", {31'd0, bus.rd}, 32'd1);
    $display("[TB] program D done at cycle %0d", cur);

    // Program E: opcode 100 with acc=0x33, sram[3]=0x11
    begin_reset();
    eprom[0] = 8'h00; eprom[1] = 8'h83; eprom[2] = 8'h20; eprom[3] = 8'hE0;
    bus.buf_in = 8'h33;
    poke(4'd3, 8'h11);
    end_reset("e");
    to_neg(6);
    check("e_id_rd", {31'd0, bus.rd}, ADD_EN ? 32'd1 : 32'd0);
    to_neg(7);
    check("e_ex_rd", {31'd0, bus.rd}, ADD_EN ? 32'd1 : 32'd0);
    to_neg(16);
    check("e_halt", {31'd0, bus.halt}, 32'd1);
    check("e_buf_out", {24'd0, bus.buf_out}, ADD_EN ? 32'h44 : 32'h33);
    check("e_carry", {31'd0, bus.carry}, 32'd0);
    $display("[TB] program E done at cycle %0d", cur);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
